// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
//   WIDTH_DEFAULT : default operand/quotient/remainder width
//   div_state_e   : controller states (IDLE, CALC, DONE)
//   DIV0_QUOT     : quotient reported for a zero divisor (all ones)
//   OVF_QUOT/REM  : result of the signed overflow case (SIGNED_DIV_EN only)
package div_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [WIDTH_DEFAULT-1:0] DIV0_QUOT = '1;

`ifdef SIGNED_DIV_EN
  // Most-negative / -1 cannot be represented; the magnitude path naturally
  // yields these values (0x8000_0000 negated is itself).
  localparam logic [WIDTH_DEFAULT-1:0] OVF_QUOT = {1'b1, {(WIDTH_DEFAULT-1){1'b0}}};
  localparam logic [WIDTH_DEFAULT-1:0] OVF_REM  = '0;
`endif

endpackage

// File: rtl/div_step.sv
// One iteration of the radix-2 restoring divider (purely combinational).
//   rem          in  WIDTH  current partial remainder
//   quo_msb      in  1      next dividend bit shifted into the remainder LSB
//   divisor      in  WIDTH  divisor
//   next_rem     out WIDTH  partial remainder after this step
//   next_quo_bit out 1      quotient bit produced by this step
//   borrow       out 1      trial subtraction went negative
// The trial subtract is a (WIDTH+1)-bit Kogge-Stone prefix adder computing
// shifted_rem + ~{0,divisor} + 1; carry-out of 0 means a borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             next_quo_bit,
  output logic             borrow
);

  localparam int N  = WIDTH + 1;
  localparam int LV = $clog2(N);

  logic [N-1:0]        a;
  logic [N-1:0]        b;
  logic [N-1:0]        sum;
  logic [N:0]          c;
  logic [LV:0][N-1:0]  g_lvl;
  logic [LV:0][N-1:0]  p_lvl;
  logic                unused_sum_msb;

  assign a    = {rem, quo_msb};
  assign b    = ~{1'b0, divisor};
  assign c[0] = 1'b1;

  genvar gi, gl;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign g_lvl[0][gi] = a[gi] & b[gi];
      assign p_lvl[0][gi] = a[gi] ^ b[gi];
    end

    for (gl = 1; gl <= LV; gl++) begin : g_level
      for (gi = 0; gi < N; gi++) begin : g_node
        if (gi >= (1 << (gl - 1))) begin : g_merge
          assign g_lvl[gl][gi] = g_lvl[gl-1][gi] |
                                 (p_lvl[gl-1][gi] & g_lvl[gl-1][gi - (1 << (gl - 1))]);
          assign p_lvl[gl][gi] = p_lvl[gl-1][gi] & p_lvl[gl-1][gi - (1 << (gl - 1))];
        end else begin : g_pass
          assign g_lvl[gl][gi] = g_lvl[gl-1][gi];
          assign p_lvl[gl][gi] = p_lvl[gl-1][gi];
        end
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_sum
      // Carry into bit gi+1 includes the forced carry-in of 1.
      assign c[gi+1] = g_lvl[LV][gi] | p_lvl[LV][gi];
      assign sum[gi] = a[gi] ^ b[gi] ^ c[gi];
    end
  endgenerate

  assign borrow       = ~c[N];
  assign next_quo_bit = c[N];
  // On success the difference is below the divisor, so its MSB is always 0.
  // On a borrow the shifted remainder is below the divisor, so a[N-1] is 0.
  assign next_rem       = borrow ? a[WIDTH-1:0] : sum[WIDTH-1:0];
  assign unused_sum_msb = sum[N-1];

endmodule

// File: rtl/restoring_divider_32bits.sv
// Multi-cycle unsigned (optionally signed) restoring divider with
// valid/ready handshakes on both sides.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   dividend, divisor     operands, latched on accept
//   is_signed             signed mode select (only with SIGNED_DIV_EN)
//   out_valid / out_ready result handshake (valid only in DONE)
//   quotient, remainder   results, updated only on entry to DONE
//   div_by_zero           set when the accepted divisor was zero
//   busy                  high while iterating
// Optional feature macro: SIGNED_DIV_EN.
// Timing: accept at edge k, WIDTH iterations on edges k+1..k+WIDTH, result
// (with sign fix-up) registered at edge k+WIDTH+1. A zero divisor skips the
// iterations and reaches DONE at edge k+1.
module restoring_divider_32bits
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SIGNED_DIV_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic             zero_reg, zero_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic             step_borrow_unused;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             sign_a;
  logic             sign_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem_reg),
    .quo_msb      (quo_reg[WIDTH-1]),
    .divisor      (dvs_reg),
    .next_rem     (step_rem),
    .next_quo_bit (step_bit),
    .borrow       (step_borrow_unused)
  );

`ifdef SIGNED_DIV_EN
  assign sign_a = is_signed & dividend[WIDTH-1];
  assign sign_b = is_signed & divisor[WIDTH-1];
`else
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
`endif
  // The most-negative value maps onto itself, which is its correct
  // unsigned magnitude.
  assign dividend_mag = sign_a ? -dividend : dividend;
  assign divisor_mag  = sign_b ? -divisor  : divisor;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    quo_next       = quo_reg;
    dvs_next       = dvs_reg;
    zero_next      = zero_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          rem_next   = '0;
          dvs_next   = divisor_mag;
          zero_next  = (divisor == '0);
          neg_q_next = sign_a ^ sign_b;
          neg_r_next = sign_a;
          state_next = CALC;
          if (divisor == '0) begin
            // Keep the raw dividend: it is reported as the remainder.
            quo_next = dividend;
            cnt_next = '0;
          end else begin
            quo_next = dividend_mag;
            cnt_next = CNT_W'(WIDTH);
          end
        end
      end

      CALC: begin
        if (cnt_reg != '0) begin
          rem_next = step_rem;
          quo_next = {quo_reg[WIDTH-2:0], step_bit};
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = DONE;
          dbz_next   = zero_reg;
          if (zero_reg) begin
            quotient_next  = DIV0_QUOT;
            remainder_next = quo_reg;
          end else begin
            quotient_next  = neg_q_reg ? -quo_reg : quo_reg;
            remainder_next = neg_r_reg ? -rem_reg : rem_reg;
          end
        end
      end

      DONE: begin
        if (out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      zero_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      quo_reg       <= quo_next;
      dvs_reg       <= dvs_next;
      zero_reg      <= zero_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign busy        = (state_reg == CALC);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_restoring_divider_32bits.sv
module tb_restoring_divider_32bits;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        busy;
`ifdef SIGNED_DIV_EN
  logic        is_signed;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  restoring_divider_32bits dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
`ifdef SIGNED_DIV_EN
    .is_signed   (is_signed),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Present operands in IDLE and let the next rising edge accept them.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_check(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r,
                           input logic z, input int exp_lat);
    int lat;
    start_op(a, b);
    if (!z) chk("busy_in_calc", {31'd0, busy}, 32'd1);
    wait_done(lat);
    $display("div %h / %h -> q=%h r=%h dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, lat);
    chk("latency", lat, exp_lat);
    chk("quotient", quotient, q);
    chk("remainder", remainder, r);
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, z});
    consume();
  endtask

  initial begin
    int bad;
    int lat;
    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,   1'b0};
    vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0};
    vecs[2]  = '{32'd5,          32'd9,          32'd0,          32'd5,   1'b0};
    vecs[3]  = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,1'b1};
    vecs[4]  = '{32'd0,          32'd5,          32'd0,          32'd0,   1'b0};
    vecs[5]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0};
    vecs[6]  = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,   1'b0};
    vecs[7]  = '{32'd1000000,    32'd1000,       32'd1000,       32'd0,   1'b0};
    vecs[8]  = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,   1'b0};
    vecs[9]  = '{32'd7,          32'd7,          32'd1,          32'd0,   1'b0};
    vecs[10] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,   1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
`ifdef SIGNED_DIV_EN
    is_signed = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_check(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].z ? 1 : 33);

    // Backpressure: result held, new operands ignored while in DONE.
    start_op(32'd100, 32'd7);
    wait_done(lat);
    chk("bp_latency", lat, 33);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_valid = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      if (i == 6) in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || quotient !== 32'd14 || remainder !== 32'd2) bad++;
    end
    $display("backpressure hold: %0d bad cycles", bad);
    chk("bp_hold", bad, 0);
    consume();
    run_check(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // Reset in the middle of an iteration run.
    start_op(32'hFFFF_FFFF, 32'd3);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) bad++;
    end
    $display("reset abort: %0d stray cycles", bad);
    chk("midrst_no_stray", bad, 0);

`ifdef SIGNED_DIV_EN
    is_signed = 1'b1;
    run_check(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_check(32'h8000_0000, 32'hFFFF_FFFF, OVF_QUOT, OVF_REM, 1'b0, 33);
    run_check(32'hFFFF_FFFB, 32'd0, DIV0_QUOT, 32'hFFFF_FFFB, 1'b0 | 1'b1, 1);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb, eq, er;
      logic        rs;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      rs = 1'($urandom_range(0, 1));
      if (rb == 32'd0) rb = 32'd1;
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
      if (rs) begin
        eq = $signed(ra) / $signed(rb);
        er = $signed(ra) % $signed(rb);
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      is_signed = rs;
      run_check(ra, rb, eq, er, 1'b0, 33);
    end
    is_signed = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
